// File: rtl/cp0_exc_ctrl_if.sv
// Pipeline-facing bundle for the CP0 exception controller: mfc0/mtc0 access,
// M-stage exception inputs and redirect outputs.
interface cp0_exc_ctrl_if;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] DIn;
    logic        WE;
    logic [31:0] PC_M;
    logic        BD_M;
    logic [4:0]  ExcCode_M;
    logic        ERET_M;
    logic [5:0]  HWInt;
    logic [31:0] DOut;
    logic        IntReq;
    logic [31:0] ExcPC;
    logic        EretReq;
    logic        Busy;

    modport master (
        output A1, A2, DIn, WE, PC_M, BD_M, ExcCode_M, ERET_M, HWInt,
        input  DOut, IntReq, ExcPC, EretReq, Busy
    );
    modport slave (
        input  A1, A2, DIn, WE, PC_M, BD_M, ExcCode_M, ERET_M, HWInt,
        output DOut, IntReq, ExcPC, EretReq, Busy
    );
endinterface

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception controller: SR/Cause/EPC/PRId, interrupt synchronizer and a
// RUN/FLUSH/HANDLER/RETURN sequencer that drives exception and eret redirects.
module cp0_exc_ctrl #(
    parameter logic [31:0] PRID    = 32'h4D4A_0001,
    parameter logic [31:0] HANDLER = 32'h0000_4180
) (
    input  logic             clk,
    input  logic             reset,
    cp0_exc_ctrl_if.slave    bus
);
    typedef enum logic [1:0] {S_RUN, S_FLUSH, S_HANDLER, S_RETURN} state_t;

    state_t      r_state;
    logic [5:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic        r_bd;
    logic [4:0]  r_exccode;
    logic [31:0] r_epc;
    logic [5:0]  r_sync1;
    logic [5:0]  r_ip;

    logic [4:0]  w_code;
    logic        w_int_pend;
    logic        w_exc_pend;
    logic        w_int_req;
    logic        w_eret_req;
    logic [31:0] w_epc_src;
    logic        w_unused;

    always_comb begin
        w_code = 5'd0;
        case (bus.ExcCode_M)
            5'd4, 5'd5, 5'd10, 5'd12: w_code = bus.ExcCode_M;
            default:                  w_code = 5'd0;
        endcase
    end

    assign w_int_pend = (|(r_ip & r_im)) & r_ie & ~r_exl;
    assign w_exc_pend = (w_code != 5'd0) & ~r_exl;
    // Gated by reset so a live ExcCode_M cannot raise IntReq while held in reset.
    assign w_int_req  = reset & (r_state == S_RUN) & (w_int_pend | w_exc_pend);
    assign w_eret_req = (r_state == S_HANDLER) & bus.ERET_M;
    assign w_epc_src  = bus.BD_M ? (bus.PC_M - 32'd4) : bus.PC_M;
    assign w_unused   = ^{w_epc_src[1:0], bus.DIn[31:16], bus.DIn[9:2]};

    assign bus.IntReq  = w_int_req;
    assign bus.EretReq = w_eret_req;
    assign bus.ExcPC   = w_int_req ? HANDLER : r_epc;
    assign bus.Busy    = (r_state != S_RUN);

    always_comb begin
        bus.DOut = 32'd0;
        case (bus.A1)
            5'd12:   bus.DOut = {16'd0, r_im, 8'd0, r_exl, r_ie};
            5'd13:   bus.DOut = {r_bd, 15'd0, r_ip, 3'd0, r_exccode, 2'd0};
            5'd14:   bus.DOut = r_epc;
            5'd15:   bus.DOut = PRID;
            default: bus.DOut = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_RUN;
            r_im      <= '0;
            r_exl     <= 1'b0;
            r_ie      <= 1'b0;
            r_bd      <= 1'b0;
            r_exccode <= '0;
            r_epc     <= '0;
            r_sync1   <= '0;
            r_ip      <= '0;
        end else begin
            r_sync1 <= bus.HWInt;
            r_ip    <= r_sync1;

            if (bus.WE && !w_int_req) begin
                case (bus.A2)
                    5'd12: begin
                        r_im <= bus.DIn[15:10];
                        r_ie <= bus.DIn[0];
                        // EXL stays pinned while a handler is in flight.
                        if (r_state == S_RUN) r_exl <= bus.DIn[1];
                    end
                    5'd14:   r_epc <= bus.DIn;
                    default: ;
                endcase
            end

            case (r_state)
                S_RUN: if (w_int_req) begin
                    r_epc     <= {w_epc_src[31:2], 2'b00};
                    r_bd      <= bus.BD_M;
                    r_exl     <= 1'b1;
                    r_exccode <= w_int_pend ? 5'd0 : w_code;
                    r_state   <= S_FLUSH;
                end
                S_FLUSH:   r_state <= S_HANDLER;
                S_HANDLER: if (bus.ERET_M) begin
                    r_exl   <= 1'b0;
                    r_state <= S_RETURN;
                end
                S_RETURN:  r_state <= S_RUN;
                default:   r_state <= S_RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl: reset, interrupt/exception entry, masking,
// eret, mtc0 conflicts and asynchronous reset abort.
`timescale 1ns/1ps
module tb_cp0_exc_ctrl;
    localparam logic [31:0] PRID    = 32'h4D4A_0001;
    localparam logic [31:0] HANDLER = 32'h0000_4180;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    cp0_exc_ctrl_if bus ();

    cp0_exc_ctrl #(.PRID(PRID), .HANDLER(HANDLER)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string tag);
        bus.A1 = a;
        #1;
        chk(tag, bus.DOut, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        bus.A1 = '0; bus.A2 = '0; bus.DIn = '0; bus.WE = 1'b0;
        bus.PC_M = '0; bus.BD_M = 1'b0; bus.ExcCode_M = '0;
        bus.ERET_M = 1'b0; bus.HWInt = '0;

        #3;
        chk("rst_intreq", {31'd0, bus.IntReq}, 32'd0);
        chk("rst_eretreq", {31'd0, bus.EretReq}, 32'd0);
        chk("rst_busy", {31'd0, bus.Busy}, 32'd0);
        chk("rst_excpc", bus.ExcPC, 32'd0);
        rd(5'd15, PRID, "rst_prid");
        rd(5'd12, 32'd0, "rst_sr");
        rd(5'd14, 32'd0, "rst_epc");
        #5 reset = 1'b1;
        tick();

        // SR write keeps only IM/EXL/IE
        bus.WE = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'hFFFF_FFFC;
        tick();
        bus.WE = 1'b0;
        rd(5'd12, 32'h0000_FC00, "sr_mask");

        bus.WE = 1'b1; bus.A2 = 5'd13; bus.DIn = 32'hFFFF_FFFF;
        tick();
        bus.WE = 1'b0;
        rd(5'd13, 32'd0, "cause_ro");

        bus.WE = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_0401;
        tick();
        bus.WE = 1'b0;
        rd(5'd12, 32'h0000_0401, "sr_write");
        rd(5'd20, 32'd0, "other_reg");

        bus.ERET_M = 1'b1;
        #1 chk("stray_eret", {31'd0, bus.EretReq}, 32'd0);
        tick();
        chk("stray_eret_busy", {31'd0, bus.Busy}, 32'd0);
        bus.ERET_M = 1'b0;

        bus.ExcCode_M = 5'd7;
        #1 chk("illegal_code", {31'd0, bus.IntReq}, 32'd0);
        bus.ExcCode_M = 5'd0;

        // Interrupt through the synchronizer, with a concurrent mtc0 EPC write
        bus.PC_M = 32'h0000_1000; bus.HWInt = 6'h01;
        #1 chk("int_lat0", {31'd0, bus.IntReq}, 32'd0);
        tick();
        chk("int_lat1", {31'd0, bus.IntReq}, 32'd0);
        tick();
        bus.WE = 1'b1; bus.A2 = 5'd14; bus.DIn = 32'h0000_5000;
        #1 chk("int_req", {31'd0, bus.IntReq}, 32'd1);
        chk("int_excpc", bus.ExcPC, HANDLER);
        chk("int_busy_run", {31'd0, bus.Busy}, 32'd0);
        tick();
        bus.WE = 1'b0; bus.HWInt = 6'h00;
        #1 chk("flush_busy", {31'd0, bus.Busy}, 32'd1);
        chk("flush_intreq", {31'd0, bus.IntReq}, 32'd0);
        rd(5'd14, 32'h0000_1000, "int_epc");
        rd(5'd13, 32'h0000_0400, "int_cause");
        rd(5'd12, 32'h0000_0403, "int_sr_exl");

        // HANDLER: everything masked
        tick();
        bus.ExcCode_M = 5'd4; bus.HWInt = 6'h3F;
        #1 chk("mask_int", {31'd0, bus.IntReq}, 32'd0);
        chk("handler_busy", {31'd0, bus.Busy}, 32'd1);
        tick();
        bus.HWInt = 6'h00;
        #1 chk("mask_int2", {31'd0, bus.IntReq}, 32'd0);
        bus.ERET_M = 1'b1; bus.WE = 1'b1; bus.A2 = 5'd14; bus.DIn = 32'h0000_2000;
        #1 chk("eret_req", {31'd0, bus.EretReq}, 32'd1);
        chk("eret_excpc_old", bus.ExcPC, 32'h0000_1000);
        tick();
        bus.WE = 1'b0;
        #1 chk("ret_eret", {31'd0, bus.EretReq}, 32'd0);
        chk("ret_intreq", {31'd0, bus.IntReq}, 32'd0);
        chk("ret_busy", {31'd0, bus.Busy}, 32'd1);
        rd(5'd14, 32'h0000_2000, "eret_epc_write");
        rd(5'd13, 32'h0000_FC00, "ret_cause_ip");
        rd(5'd12, 32'h0000_0401, "ret_sr_exl0");
        bus.ERET_M = 1'b0; bus.ExcCode_M = 5'd0;
        tick();
        chk("run_busy", {31'd0, bus.Busy}, 32'd0);
        chk("run_idle", {31'd0, bus.IntReq}, 32'd0);

        // Exception in a delay slot
        bus.ExcCode_M = 5'd10; bus.BD_M = 1'b1; bus.PC_M = 32'h0000_3010;
        #1 chk("ds_req", {31'd0, bus.IntReq}, 32'd1);
        tick();
        bus.ExcCode_M = 5'd0; bus.BD_M = 1'b0;
        #1 chk("ds_flush", {31'd0, bus.Busy}, 32'd1);
        rd(5'd14, 32'h0000_300C, "ds_epc");
        rd(5'd13, 32'h8000_0028, "ds_cause");
        tick();
        chk("ds_handler", {31'd0, bus.Busy}, 32'd1);
        bus.ERET_M = 1'b1;
        #1 chk("ds_eret", {31'd0, bus.EretReq}, 32'd1);
        chk("ds_excpc", bus.ExcPC, 32'h0000_300C);
        tick();
        bus.ERET_M = 1'b0;
        #1 chk("ds_return", {31'd0, bus.Busy}, 32'd1);
        tick();
        chk("ds_run", {31'd0, bus.Busy}, 32'd0);

        // Interrupt beats a same-cycle exception
        bus.HWInt = 6'h01;
        tick();
        tick();
        bus.ExcCode_M = 5'd12; bus.PC_M = 32'h0000_4000;
        #1 chk("pri_req", {31'd0, bus.IntReq}, 32'd1);
        tick();
        bus.ExcCode_M = 5'd0; bus.HWInt = 6'h00;
        #1 chk("pri_single_pulse", {31'd0, bus.IntReq}, 32'd0);
        rd(5'd13, 32'h0000_0400, "pri_cause");
        chk("pri_busy", {31'd0, bus.Busy}, 32'd1);

        // Asynchronous reset mid-FLUSH
        bus.ExcCode_M = 5'd5;
        reset = 1'b0;
        #1 chk("arst_busy", {31'd0, bus.Busy}, 32'd0);
        chk("arst_intreq", {31'd0, bus.IntReq}, 32'd0);
        chk("arst_eretreq", {31'd0, bus.EretReq}, 32'd0);
        chk("arst_excpc", bus.ExcPC, 32'd0);
        rd(5'd15, PRID, "arst_prid");
        rd(5'd14, 32'd0, "arst_epc");
        rd(5'd13, 32'd0, "arst_cause");
        bus.ExcCode_M = 5'd0;
        reset = 1'b1;
        tick();
        chk("post_rst_busy", {31'd0, bus.Busy}, 32'd0);
        rd(5'd12, 32'd0, "post_rst_sr");
        bus.ExcCode_M = 5'd5; bus.PC_M = 32'h0000_5000;
        #1 chk("post_rst_exc", {31'd0, bus.IntReq}, 32'd1);
        tick();
        bus.ExcCode_M = 5'd0;
        #1 chk("post_rst_flush", {31'd0, bus.Busy}, 32'd1);
        rd(5'd13, 32'h0000_0014, "post_rst_cause");
        rd(5'd14, 32'h0000_5000, "post_rst_epc");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
